// File: rtl/dma_window_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dma_window_streamer_if
//  Description : Bus bundle for dma_window_streamer. Carries three groups of
//                signals:
//                  - RAM port   : ram_addr, ram_rd, ram_rdata, ram_we, ram_wdata
//                  - window out : win_valid, win_ready, win_data
//                  - result in  : res_valid, res_data, res_ready
//                Modport "master" is the streamer side. Modport "slave" is the
//                environment side (RAM controller plus compute unit).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dma_window_streamer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int WIN    = 5
);
    // RAM controller port
    logic [ADDR_W-1:0]         ram_addr;
    logic                      ram_rd;
    logic [DATA_W-1:0]         ram_rdata;
    logic                      ram_we;
    logic [DATA_W-1:0]         ram_wdata;

    // Window stream towards the compute unit
    logic                      win_valid;
    logic                      win_ready;
    logic [WIN*WIN*DATA_W-1:0] win_data;

    // Result stream from the compute unit
    logic                      res_valid;
    logic [DATA_W-1:0]         res_data;
    logic                      res_ready;

    modport master (
        output ram_addr, ram_rd, ram_we, ram_wdata,
        input  ram_rdata,
        output win_valid, win_data,
        input  win_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  ram_addr, ram_rd, ram_we, ram_wdata,
        output ram_rdata,
        input  win_valid, win_data,
        output win_ready,
        output res_valid, res_data,
        input  res_ready
    );
endinterface
`default_nettype wire

// File: rtl/dma_window_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : dma_window_streamer
//  Description : Image DMA for the conv/pool accelerator. Operation:
//                  1. Loads an N x N image of words from RAM into a local
//                     buffer.
//                  2. Streams WIN x WIN convolution windows (stride 1) or
//                     2 x 2 pooling windows (stride 2) over a valid/ready
//                     handshake.
//                  3. Writes the returned results back to RAM sequentially.
//  Ports       : clk, rst_n (async, active low)
//                start/pooling/img_size/src_addr/dst_addr - job request
//                bus (dma_window_streamer_if.master)      - RAM, window and
//                                                           result streams
//                busy/done/err                            - job status
//  Options     : define DMA_RELU_EN to clamp negative results to zero
//                before they are written back.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_window_streamer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13,
    parameter int MAX_IMG = 32,
    parameter int WIN     = 5,
    parameter int SZ_W    = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              pooling,
    input  wire logic [SZ_W-1:0]   img_size,
    input  wire logic [ADDR_W-1:0] src_addr,
    input  wire logic [ADDR_W-1:0] dst_addr,
    dma_window_streamer_if.master  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    // Row/column index width. The buffer is addressed as {row, col}, so it
    // is a square power of two. Any row or column index is then in range,
    // even when an unused window tap wraps past the image edge.
    localparam int RC_W  = (MAX_IMG > 1) ? $clog2(MAX_IMG) : 1;
    localparam int BUF_D = 1 << (2 * RC_W);
    localparam int CNT_W = $clog2(MAX_IMG * MAX_IMG + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Job parameters, captured on start
    logic              r_pool;
    logic              r_illegal;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [SZ_W-1:0]   r_n;
    logic [RC_W-1:0]   r_lim;     // last valid origin row/col
    logic [CNT_W-1:0]  r_total;   // N*N words to load
    logic [CNT_W-1:0]  r_k;       // window/result count

    // Load side
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [RC_W-1:0]   r_ld_row;
    logic [RC_W-1:0]   r_ld_col;
    logic              r_cap_vld;
    logic [2*RC_W-1:0] r_cap_idx;
    logic [DATA_W-1:0] r_buf [BUF_D];

    // Stream side
    logic [RC_W-1:0]   r_org_r;
    logic [RC_W-1:0]   r_org_c;

    // Write-back side
    logic [CNT_W-1:0]  r_res_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wdata;

    // Combinational helpers
    logic                      w_legal;
    logic [SZ_W-1:0]           w_side;
    logic [CNT_W-1:0]          w_k;
    logic [CNT_W-1:0]          w_total;
    logic [RC_W-1:0]           w_lim;
    logic                      w_accept;
    logic                      w_rd;
    logic                      w_ld_col_last;
    logic                      w_win_valid;
    logic                      w_win_hs;
    logic                      w_last_win;
    logic [RC_W-1:0]           w_step;
    logic                      w_res_rdy;
    logic                      w_res_hs;
    logic [DATA_W-1:0]         w_res_word;
    logic [WIN*WIN*DATA_W-1:0] w_win;

    // ------------------------------------------------------------------
    // Job decode, evaluated on the request inputs while idle
    // ------------------------------------------------------------------
    always_comb begin
        w_legal = 1'b1;
        if ((img_size == '0) || (img_size > SZ_W'(MAX_IMG))) begin
            w_legal = 1'b0;
        end else if (pooling) begin
            if (img_size[0] || (img_size < SZ_W'(2))) begin
                w_legal = 1'b0;
            end
        end else if (img_size < SZ_W'(WIN)) begin
            w_legal = 1'b0;
        end
    end

    // Windows per side. This value is meaningless for an illegal job, but
    // it is never used in that case.
    assign w_side   = pooling ? (img_size >> 1)
                              : (img_size - SZ_W'(WIN) + SZ_W'(1));
    assign w_k      = CNT_W'(w_side) * CNT_W'(w_side);
    assign w_total  = CNT_W'(img_size) * CNT_W'(img_size);
    assign w_lim    = pooling ? RC_W'(img_size - SZ_W'(2))
                              : RC_W'(img_size - SZ_W'(WIN));
    assign w_accept = (r_state == S_IDLE) && start;

    // ------------------------------------------------------------------
    // Handshake and strobe terms
    // ------------------------------------------------------------------
    assign w_rd          = (r_state == S_LOAD) && (r_rd_cnt != r_total);
    assign w_ld_col_last = (r_ld_col == RC_W'(r_n - SZ_W'(1)));
    assign w_win_valid   = (r_state == S_STREAM);
    assign w_win_hs      = w_win_valid && bus.win_ready;
    assign w_last_win    = (r_org_r == r_lim) && (r_org_c == r_lim);
    assign w_step        = r_pool ? RC_W'(2) : RC_W'(1);
    assign w_res_rdy     = ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                           (r_res_cnt != r_k);
    assign w_res_hs      = w_res_rdy && bus.res_valid;

`ifdef DMA_RELU_EN
    assign w_res_word = bus.res_data[DATA_W-1] ? '0 : bus.res_data;
`else
    assign w_res_word = bus.res_data;
`endif

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_legal ? S_LOAD : S_DONE;
                end
            end
            // Every read has been issued once the counter reaches N*N. The
            // last word is captured during this extra cycle.
            S_LOAD: begin
                if (r_rd_cnt == r_total) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_win_hs && w_last_win) begin
                    w_next = S_DRAIN;
                end
            end
            // The write for the final handshake is on the bus in the same
            // cycle the count reaches K, so no extra wait is needed.
            S_DRAIN: begin
                if (r_res_cnt == r_k) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pool    <= 1'b0;
            r_illegal <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_n       <= '0;
            r_lim     <= '0;
            r_total   <= '0;
            r_k       <= '0;
            r_rd_cnt  <= '0;
            r_ld_row  <= '0;
            r_ld_col  <= '0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            r_org_r   <= '0;
            r_org_c   <= '0;
            r_res_cnt <= '0;
            r_we      <= 1'b0;
            r_wr_addr <= '0;
            r_wdata   <= '0;
        end else begin
            // Read data comes back one cycle after its strobe. Carry the
            // target slot forward by one cycle so it lines up with the data.
            r_cap_vld <= w_rd;
            r_cap_idx <= {r_ld_row, r_ld_col};

            if (w_accept) begin
                r_pool    <= pooling;
                r_illegal <= ~w_legal;
                r_src     <= src_addr;
                r_dst     <= dst_addr;
                r_n       <= img_size;
                r_lim     <= w_lim;
                r_total   <= w_total;
                r_k       <= w_k;
                r_rd_cnt  <= '0;
                r_ld_row  <= '0;
                r_ld_col  <= '0;
                r_org_r   <= '0;
                r_org_c   <= '0;
                r_res_cnt <= '0;
            end

            if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                if (w_ld_col_last) begin
                    r_ld_col <= '0;
                    r_ld_row <= r_ld_row + RC_W'(1);
                end else begin
                    r_ld_col <= r_ld_col + RC_W'(1);
                end
            end

            // Raster walk over window origins. After the last window the
            // row goes past the limit, but the FSM leaves STREAM on that
            // same handshake.
            if (w_win_hs) begin
                if (r_org_c == r_lim) begin
                    r_org_c <= '0;
                    r_org_r <= r_org_r + w_step;
                end else begin
                    r_org_c <= r_org_c + w_step;
                end
            end

            r_we <= w_res_hs;
            if (w_res_hs) begin
                r_wr_addr <= r_dst + ADDR_W'(r_res_cnt);
                r_wdata   <= w_res_word;
                r_res_cnt <= r_res_cnt + CNT_W'(1);
            end
        end
    end

    // Image buffer. Its contents are don't-care after reset, so it has no
    // reset term and can map onto RAM.
    always_ff @(posedge clk) begin
        if (r_cap_vld) begin
            r_buf[r_cap_idx] <= bus.ram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Window assembly: tap [r][c] reads buffer cell (origin_r+r,
    // origin_c+c). In pool mode only the top-left 2x2 taps are live. All
    // taps are forced to zero outside STREAM, so nothing stale from the
    // buffer leaks onto the bus.
    // ------------------------------------------------------------------
    for (genvar gr = 0; gr < WIN; gr++) begin : g_row
        for (genvar gc = 0; gc < WIN; gc++) begin : g_col
            localparam bit c_pool_tap = (gr < 2) && (gc < 2);
            logic [RC_W-1:0] w_row;
            logic [RC_W-1:0] w_col;
            assign w_row = r_org_r + RC_W'(gr);
            assign w_col = r_org_c + RC_W'(gc);
            assign w_win[(gr*WIN+gc)*DATA_W +: DATA_W] =
                (w_win_valid && (!r_pool || c_pool_tap)) ? r_buf[{w_row, w_col}]
                                                         : '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ram_rd    = w_rd;
    assign bus.ram_addr  = w_rd ? (r_src + ADDR_W'(r_rd_cnt)) : r_wr_addr;
    assign bus.ram_we    = r_we;
    assign bus.ram_wdata = r_wdata;
    assign bus.win_valid = w_win_valid;
    assign bus.win_data  = w_win;
    assign bus.res_ready = w_res_rdy;

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign err  = (r_state == S_DONE) && r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_dma_window_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_window_streamer
//  Description : Directed self-checking bench for dma_window_streamer.
//                Covers: conv, pool, backpressure, illegal jobs, size
//                boundaries, mid-job reset and result overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_window_streamer;

    localparam int WIN = 5;
    localparam int WW  = WIN * WIN * 16;

`ifdef DMA_RELU_EN
    localparam logic [15:0] NEG_EXP = 16'h0000;
`else
    localparam logic [15:0] NEG_EXP = 16'hFFFD;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pooling;
    logic [5:0]  img_size;
    logic [12:0] src_addr;
    logic [12:0] dst_addr;
    logic        busy;
    logic        done;
    logic        err;

    dma_window_streamer_if #(.DATA_W(16), .ADDR_W(13), .WIN(WIN)) bus ();

    dma_window_streamer #(
        .DATA_W(16), .ADDR_W(13), .MAX_IMG(32), .WIN(WIN), .SZ_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pooling(pooling),
        .img_size(img_size), .src_addr(src_addr), .dst_addr(dst_addr),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data is returned one cycle after the strobe.
    logic [15:0] mem [8192];
    always @(posedge clk) begin
        bus.ram_rdata <= bus.ram_rd ? mem[bus.ram_addr] : 16'h0;
    end

    int n_checks;
    int n_pass;

    // Per-job observations
    logic [WW-1:0] win_q [$];
    logic [12:0]   wa_q  [$];
    logic [15:0]   wd_q  [$];
    logic [15:0]   res_vals [8];
    int rd_cnt, rd_addr_bad, both_hi, done_cnt, err_at_done, err_stray;
    int unstable, rdy_viol, load_cycles, timeout;

    function automatic logic [15:0] el(input logic [WW-1:0] w, input int r, input int c);
        return w[(r*WIN+c)*16 +: 16];
    endfunction

    // Runs one job cycle by cycle and records what the DUT does.
    // Inputs are driven at the falling edge and outputs sampled 1 ns later.
    task automatic run_job(input bit pool, input logic [5:0] n, input logic [12:0] src,
                           input logic [12:0] dst, input int n_res, input int k,
                           input bit toggle);
        int cyc, sent, acc, post;
        bit done_seen, stalled, saw_win;
        logic [WW-1:0] prev;
        logic [12:0] exp_a;
        for (int i = 0; i < int'(n) * int'(n); i++) mem[13'(src + 13'(i))] = 16'(i);
        win_q.delete(); wa_q.delete(); wd_q.delete();
        rd_cnt = 0; rd_addr_bad = 0; both_hi = 0; done_cnt = 0; err_at_done = 0;
        err_stray = 0; unstable = 0; rdy_viol = 0; load_cycles = 0; timeout = 0;
        cyc = 0; sent = 0; acc = 0; post = 0; done_seen = 0; stalled = 0; saw_win = 0;
        prev = '0;
        @(negedge clk);
        start = 1'b1; pooling = pool; img_size = n; src_addr = src; dst_addr = dst;
        forever begin
            bus.win_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            bus.res_valid = (sent < n_res);
            bus.res_data  = res_vals[sent % 8];
            #1;
            if (bus.ram_rd) begin
                exp_a = src + 13'(rd_cnt);
                if (bus.ram_addr !== exp_a) rd_addr_bad++;
                rd_cnt++;
            end
            if (bus.ram_rd && bus.ram_we) both_hi++;
            if (bus.ram_we === 1'b1) begin
                wa_q.push_back(bus.ram_addr);
                wd_q.push_back(bus.ram_wdata);
            end
            if (busy && !bus.win_valid && !saw_win) load_cycles++;
            if (bus.win_valid) begin
                saw_win = 1;
                if (stalled && (bus.win_data !== prev)) unstable++;
                if (bus.win_ready) begin
                    win_q.push_back(bus.win_data);
                    stalled = 0;
                end else begin
                    stalled = 1;
                end
                prev = bus.win_data;
            end else begin
                stalled = 0;
            end
            if (bus.res_ready && (acc >= k)) rdy_viol++;
            if (bus.res_valid) begin
                if (bus.res_ready) begin
                    acc++;
                    sent++;
                end else if (acc >= k) begin
                    sent++;
                end
            end
            if (done) begin
                done_cnt++;
                if (err) err_at_done++;
                done_seen = 1;
            end
            if (err && !done) err_stray++;
            if (done_seen) post++;
            cyc++;
            if (done_seen && (sent >= n_res) && (post >= 3)) break;
            if (cyc > 3000) begin
                timeout = 1;
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0; bus.res_valid = 1'b0; bus.win_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, err, bus.ram_rd, bus.ram_we, bus.win_valid, bus.res_ready} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b expected 0",
                     {busy, done, err, bus.ram_rd, bus.ram_we, bus.win_valid, bus.res_ready});
        end else n_pass++;
        n_checks++;
        if ({bus.ram_addr, bus.ram_wdata} !== 29'b0) begin
            $display("FAIL reset_bus: got %h expected 0", {bus.ram_addr, bus.ram_wdata});
        end else n_pass++;
        n_checks++;
        if (bus.win_data !== '0) $display("FAIL reset_win: got nonzero expected 0");
        else n_pass++;
    endtask

    task automatic test_conv();
        for (int j = 0; j < 8; j++) res_vals[j] = 16'(100 + j);
        run_job(1'b0, 6'd6, 13'd100, 13'd2000, 4, 4, 1'b0);
        n_checks++; if (timeout !== 0) $display("FAIL conv_timeout: got %0d expected 0", timeout); else n_pass++;
        n_checks++; if (load_cycles !== 37) $display("FAIL conv_load_cycles: got %0d expected 37", load_cycles); else n_pass++;
        n_checks++; if (rd_cnt !== 36) $display("FAIL conv_reads: got %0d expected 36", rd_cnt); else n_pass++;
        n_checks++; if (rd_addr_bad !== 0) $display("FAIL conv_rd_addr: got %0d bad expected 0", rd_addr_bad); else n_pass++;
        n_checks++; if (win_q.size() !== 4) $display("FAIL conv_win_count: got %0d expected 4", win_q.size()); else n_pass++;
        n_checks++; if (el(win_q[0], 0, 0) !== 16'd0) $display("FAIL conv_w0_00: got %0d expected 0", el(win_q[0], 0, 0)); else n_pass++;
        n_checks++; if (el(win_q[0], 4, 4) !== 16'd28) $display("FAIL conv_w0_44: got %0d expected 28", el(win_q[0], 4, 4)); else n_pass++;
        n_checks++; if (el(win_q[1], 0, 0) !== 16'd1) $display("FAIL conv_w1_00: got %0d expected 1", el(win_q[1], 0, 0)); else n_pass++;
        n_checks++; if (el(win_q[2], 2, 3) !== 16'd21) $display("FAIL conv_w2_23: got %0d expected 21", el(win_q[2], 2, 3)); else n_pass++;
        n_checks++; if (el(win_q[3], 0, 0) !== 16'd7) $display("FAIL conv_w3_00: got %0d expected 7", el(win_q[3], 0, 0)); else n_pass++;
        n_checks++; if (wa_q.size() !== 4) $display("FAIL conv_wr_count: got %0d expected 4", wa_q.size()); else n_pass++;
        for (int j = 0; j < wa_q.size(); j++) begin
            n_checks++;
            if ((wa_q[j] !== 13'(2000 + j)) || (wd_q[j] !== 16'(100 + j)))
                $display("FAIL conv_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                         j, wa_q[j], wd_q[j], 2000 + j, 100 + j);
            else n_pass++;
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL conv_done: got %0d pulses expected 1", done_cnt); else n_pass++;
        n_checks++; if ((err_at_done | err_stray) !== 0) $display("FAIL conv_err: got %0d expected 0", err_at_done + err_stray); else n_pass++;
        n_checks++; if (both_hi !== 0) $display("FAIL conv_rd_we: got %0d overlaps expected 0", both_hi); else n_pass++;
    endtask

    task automatic test_pool();
        logic [WW-1:0] m;
        logic [15:0] exp_el [4][4];
        m = '0;
        m[0*16 +: 16] = '1; m[1*16 +: 16] = '1; m[5*16 +: 16] = '1; m[6*16 +: 16] = '1;
        exp_el = '{'{0, 1, 4, 5}, '{2, 3, 6, 7}, '{8, 9, 12, 13}, '{10, 11, 14, 15}};
        for (int j = 0; j < 8; j++) res_vals[j] = 16'(200 + j);
        // Base address near the top of the space, so the read range wraps
        run_job(1'b1, 6'd4, 13'h1FFE, 13'd500, 4, 4, 1'b0);
        n_checks++; if (timeout !== 0) $display("FAIL pool_timeout: got %0d expected 0", timeout); else n_pass++;
        n_checks++; if ((rd_cnt !== 16) || (rd_addr_bad !== 0))
            $display("FAIL pool_reads: got %0d reads %0d bad expected 16 reads 0 bad", rd_cnt, rd_addr_bad); else n_pass++;
        n_checks++; if (win_q.size() !== 4) $display("FAIL pool_win_count: got %0d expected 4", win_q.size()); else n_pass++;
        for (int w = 0; w < win_q.size() && w < 4; w++) begin
            n_checks++;
            if ({el(win_q[w], 0, 0), el(win_q[w], 0, 1), el(win_q[w], 1, 0), el(win_q[w], 1, 1)} !==
                {exp_el[w][0], exp_el[w][1], exp_el[w][2], exp_el[w][3]})
                $display("FAIL pool_w%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d", w,
                         el(win_q[w], 0, 0), el(win_q[w], 0, 1), el(win_q[w], 1, 0), el(win_q[w], 1, 1),
                         exp_el[w][0], exp_el[w][1], exp_el[w][2], exp_el[w][3]);
            else n_pass++;
            n_checks++;
            if ((win_q[w] & ~m) !== '0) $display("FAIL pool_unused%0d: got nonzero unused bits expected 0", w);
            else n_pass++;
        end
        n_checks++; if ((wa_q.size() !== 4) || (wa_q[3] !== 13'd503) || (wd_q[3] !== 16'd203))
            $display("FAIL pool_writes: got %0d writes last %0d/%0d expected 4 last 503/203",
                     wa_q.size(), wa_q[3], wd_q[3]); else n_pass++;
        n_checks++; if ((done_cnt !== 1) || (err_at_done !== 0))
            $display("FAIL pool_done: got %0d done %0d err expected 1 0", done_cnt, err_at_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp00 [4];
        exp00 = '{0, 1, 6, 7};
        for (int j = 0; j < 8; j++) res_vals[j] = 16'(300 + j);
        run_job(1'b0, 6'd6, 13'd100, 13'd3000, 4, 4, 1'b1);
        n_checks++; if (timeout !== 0) $display("FAIL bp_timeout: got %0d expected 0", timeout); else n_pass++;
        n_checks++; if (win_q.size() !== 4) $display("FAIL bp_handshakes: got %0d expected 4", win_q.size()); else n_pass++;
        for (int w = 0; w < win_q.size() && w < 4; w++) begin
            n_checks++;
            if (el(win_q[w], 0, 0) !== exp00[w])
                $display("FAIL bp_w%0d_00: got %0d expected %0d", w, el(win_q[w], 0, 0), exp00[w]);
            else n_pass++;
        end
        n_checks++; if (unstable !== 0) $display("FAIL bp_stable: got %0d changes expected 0", unstable); else n_pass++;
        n_checks++; if (wa_q.size() !== 4) $display("FAIL bp_writes: got %0d expected 4", wa_q.size()); else n_pass++;
    endtask

    task automatic test_illegal();
        bit          pl [4];
        logic [5:0]  ns [4];
        pl = '{1'b0, 1'b1, 1'b0, 1'b0};
        ns = '{6'd3, 6'd5, 6'd0, 6'd33};
        for (int t = 0; t < 4; t++) begin
            run_job(pl[t], ns[t], 13'd50, 13'd60, 0, 0, 1'b0);
            n_checks++;
            if ((timeout !== 0) || (done_cnt !== 1) || (err_at_done !== 1) || (err_stray !== 0))
                $display("FAIL illegal%0d_status: got timeout %0d done %0d err %0d stray %0d expected 0 1 1 0",
                         t, timeout, done_cnt, err_at_done, err_stray);
            else n_pass++;
            n_checks++;
            if ((rd_cnt !== 0) || (wa_q.size() !== 0) || (rdy_viol !== 0) || (win_q.size() !== 0))
                $display("FAIL illegal%0d_bus: got rd %0d wr %0d rdy %0d win %0d expected all 0",
                         t, rd_cnt, wa_q.size(), rdy_viol, win_q.size());
            else n_pass++;
        end
    endtask

    task automatic test_boundary();
        res_vals[0] = 16'd42;
        run_job(1'b0, 6'd5, 13'd10, 13'd700, 1, 1, 1'b0);
        n_checks++; if ((timeout !== 0) || (load_cycles !== 26))
            $display("FAIL conv5_load: got %0d cycles timeout %0d expected 26 0", load_cycles, timeout); else n_pass++;
        n_checks++; if ((win_q.size() !== 1) || (el(win_q[0], 4, 4) !== 16'd24) || (el(win_q[0], 2, 1) !== 16'd11))
            $display("FAIL conv5_win: got %0d windows [4][4]=%0d [2][1]=%0d expected 1 24 11",
                     win_q.size(), el(win_q[0], 4, 4), el(win_q[0], 2, 1)); else n_pass++;
        n_checks++; if ((wa_q.size() !== 1) || (wa_q[0] !== 13'd700) || (wd_q[0] !== 16'd42))
            $display("FAIL conv5_write: got %0d writes %0d/%0d expected 1 700/42",
                     wa_q.size(), wa_q[0], wd_q[0]); else n_pass++;
        res_vals[0] = 16'd77;
        run_job(1'b1, 6'd2, 13'd20, 13'd800, 1, 1, 1'b0);
        n_checks++; if ((win_q.size() !== 1) ||
                        ({el(win_q[0], 0, 0), el(win_q[0], 0, 1), el(win_q[0], 1, 0), el(win_q[0], 1, 1)} !==
                         {16'd0, 16'd1, 16'd2, 16'd3}))
            $display("FAIL pool2_win: got %0d windows %0d %0d %0d %0d expected 1 0 1 2 3", win_q.size(),
                     el(win_q[0], 0, 0), el(win_q[0], 0, 1), el(win_q[0], 1, 0), el(win_q[0], 1, 1)); else n_pass++;
        n_checks++; if ((done_cnt !== 1) || (err_at_done !== 0) || (wa_q.size() !== 1))
            $display("FAIL pool2_done: got done %0d err %0d wr %0d expected 1 0 1",
                     done_cnt, err_at_done, wa_q.size()); else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 36; i++) mem[13'(100 + i)] = 16'(i);
        @(negedge clk);
        start = 1'b1; pooling = 1'b0; img_size = 6'd6; src_addr = 13'd100; dst_addr = 13'd900;
        bus.win_ready = 1'b1; bus.res_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if ((busy !== 1'b1) || (bus.ram_rd !== 1'b1))
            $display("FAIL mrst_in_load: got busy %b rd %b expected 1 1", busy, bus.ram_rd); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, bus.ram_rd, bus.ram_we, bus.win_valid, bus.res_ready} !== 7'b0)
            $display("FAIL mrst_ctrl: got %b expected 0",
                     {busy, done, err, bus.ram_rd, bus.ram_we, bus.win_valid, bus.res_ready});
        else n_pass++;
        n_checks++;
        if (({bus.ram_addr, bus.ram_wdata} !== 29'b0) || (bus.win_data !== '0))
            $display("FAIL mrst_bus: got addr %0d wdata %0d expected 0 0", bus.ram_addr, bus.ram_wdata);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) res_vals[j] = 16'(400 + j);
        run_job(1'b0, 6'd6, 13'd100, 13'd900, 4, 4, 1'b0);
        n_checks++; if ((timeout !== 0) || (win_q.size() !== 4) || (el(win_q[3], 0, 0) !== 16'd7))
            $display("FAIL mrst_rerun_win: got %0d windows w3=%0d expected 4 7",
                     win_q.size(), el(win_q[3], 0, 0)); else n_pass++;
        n_checks++; if ((wa_q.size() !== 4) || (done_cnt !== 1) || (err_at_done !== 0) || (load_cycles !== 37))
            $display("FAIL mrst_rerun_job: got wr %0d done %0d err %0d load %0d expected 4 1 0 37",
                     wa_q.size(), done_cnt, err_at_done, load_cycles); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [15:0] exp_d [4];
        res_vals = '{16'd5, 16'hFFFD, 16'd7, 16'd9, 16'd11, 16'd13, 16'd0, 16'd0};
        exp_d    = '{16'd5, NEG_EXP, 16'd7, 16'd9};
        run_job(1'b0, 6'd6, 13'd100, 13'd4000, 6, 4, 1'b0);
        n_checks++; if (timeout !== 0) $display("FAIL ovr_timeout: got %0d expected 0", timeout); else n_pass++;
        n_checks++; if (wa_q.size() !== 4) $display("FAIL ovr_writes: got %0d expected 4", wa_q.size()); else n_pass++;
        n_checks++; if (rdy_viol !== 0) $display("FAIL ovr_ready: got %0d high cycles after K expected 0", rdy_viol); else n_pass++;
        for (int j = 0; j < wa_q.size() && j < 4; j++) begin
            n_checks++;
            if ((wa_q[j] !== 13'(4000 + j)) || (wd_q[j] !== exp_d[j]))
                $display("FAIL ovr_write%0d: got addr %0d data %h expected addr %0d data %h",
                         j, wa_q[j], wd_q[j], 4000 + j, exp_d[j]);
            else n_pass++;
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL ovr_done: got %0d expected 1", done_cnt); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; pooling = 1'b0; img_size = '0;
        src_addr = '0; dst_addr = '0;
        bus.win_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
        for (int i = 0; i < 8; i++) res_vals[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_conv();
        test_pool();
        test_back_to_back();
        test_illegal();
        test_boundary();
        test_mid_reset();
        test_overrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_window_streamer.md
Name: dma_window_streamer

Overview:
- Parametrised successor to the accelerator's image DMA.
- Loads an N×N image of 16-bit words from RAM into a local buffer.
- Streams convolution windows (WIN×WIN, stride 1) or pooling windows (2×2, stride 2) to the compute unit over a valid/ready handshake.
- Writes the compute unit's results back to RAM sequentially.
- Sits between the RAM controller and the conv/pool datapath.

Parameters:
- DATA_W, 16: word width.
- ADDR_W, 13: RAM address width.
- MAX_IMG, 32: maximum image side N.
- WIN, 5: convolution window side.
- SZ_W, 6: width of img_size; must hold MAX_IMG.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- pooling  in  1  0 = conv mode, 1 = pool mode; sampled with start.
- img_size  in  SZ_W  image side N; sampled with start.
- src_addr  in  ADDR_W  image base address; sampled with start.
- dst_addr  in  ADDR_W  result base address; sampled with start.
- ram_addr  out  ADDR_W  RAM address.
- ram_rd  out  1  read strobe; read data returns the next cycle.
- ram_rdata  in  DATA_W  read data.
- ram_we  out  1  write strobe.
- ram_wdata  out  DATA_W  write data.
- win_valid  out  1  window present.
- win_ready  in  1  compute unit accepts the window.
- win_data  out  WIN*WIN*DATA_W  window, row-major; element [r][c] sits at bits (r*WIN+c)*DATA_W.
- res_valid  in  1  result present.
- res_data  in  DATA_W  result word, signed.
- res_ready  out  1  block accepts the result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse, coincident with done, for an illegal job.

Behaviour:
- Reset (asynchronous, any state, including mid-job):
  - state returns to IDLE; all outputs go to 0; counters clear.
  - Buffer contents are don't-care.
- States: IDLE → LOAD → STREAM → DRAIN → DONE → IDLE.
- IDLE:
  - start=1 latches pooling, img_size, src_addr and dst_addr.
  - Legality check:
    - illegal if N > MAX_IMG or N = 0;
    - conv: illegal if N < WIN;
    - pool: illegal if N is odd or N < 2.
  - Illegal job → DONE with err=1; no RAM access at all.
  - Legal job → LOAD.
  - start is ignored while busy.
- LOAD:
  - ram_rd=1 for N*N consecutive cycles, addresses src_addr .. src_addr+N*N-1 (ADDR_W wrap-around).
  - Each ram_rdata is captured the cycle after its strobe and stored row-major.
  - Leaves the state one cycle after the last strobe, so LOAD lasts N*N+1 cycles.
- STREAM:
  - Windows are issued raster order, top-left origin first.
  - Conv: origins (r,c), r,c ∈ [0, N-WIN]; window count K = (N-WIN+1)².
  - Pool: origins (2r,2c), r,c ∈ [0, N/2-1]; K = (N/2)².
    - Only elements [0][0], [0][1], [1][0], [1][1] are populated; all other win_data bits are 0.
  - win_valid rises the first STREAM cycle.
  - win_data is held stable while win_valid=1 and win_ready=0.
  - On handshake the next window appears the following cycle, giving one window per cycle when win_ready stays high.
  - After the K-th handshake: win_valid=0, go to DRAIN.
- Results (STREAM and DRAIN):
  - res_ready=1 while results received < K.
  - Each handshake registers ram_we=1, ram_addr=dst_addr+idx, ram_wdata=res_data on the next cycle; idx increments from 0.
  - Results may arrive before STREAM ends.
  - Once K results are received, res_ready=0 and further res_valid is ignored.
- DRAIN:
  - Waits until K results are received and the final write is issued.
  - Then → DONE.
- DONE: done=1 (err set if illegal) for one cycle, then → IDLE.
- RAM port use: reads occur only in LOAD, writes only in STREAM/DRAIN, so ram_rd and ram_we are never both high.

Optional Feature:
- Macro DMA_RELU_EN.
  - Defined: each result written back is max(res_data, 0), treating res_data as signed, so a negative value writes 0.
  - Undefined: res_data is written unchanged.
- Latency and handshakes are identical in both builds.

Test Plan:
- Conv, N=6, WIN=5, RAM[src+i]=i, win_ready=1 → LOAD spans 37 cycles, then 4 windows.
  - Window 0 [0][0]=0, [4][4]=28.
  - Window 1 [0][0]=1.
  - Window 3 [0][0]=7.
  - 4 results written at dst..dst+3; done pulses once; err=0.
- Pool, N=4 → 4 windows.
  - Window 0 elements {0,1,4,5}; window 3 elements {10,11,14,15}.
  - All unused win_data bits are 0.
- Backpressure: win_ready toggling 0/1 every cycle in the conv N=6 case → win_data stable across stall cycles; exactly 4 handshakes; no window skipped or duplicated.
- Illegal jobs: conv N=3, pool N=5, N=0 → done and err pulse together; ram_rd and ram_we never asserted.
- Mid-job reset: rst_n low during LOAD cycle 10 → all outputs 0 immediately; a subsequent start runs cleanly.
- Overrun: 6 res_valid pulses sent for K=4 → only 4 writes; res_ready low after the 4th; with DMA_RELU_EN, res_data=-3 writes 0.
